clk_sel_divider: RTL and testbench
==================================

Name: clk_sel_divider

Overview:
- Parametrised successor to the team's 2:1 clock-select mux. Selects one of NUM_CH programmable divide channels and produces a registered divided clock s_clk plus a one-cycle strobe s_stb, all in a single clock domain.
- Unlike the combinational mux, a selection change never truncates or stretches a pulse. The switch takes effect only at the end of the current output period.
- Sits between the system clock and downstream logic that needs a selectable slow-rate enable or clock.

Parameters:
- NUM_CH, 4, number of selectable divide channels (2..16).
- DIV_W, 8, width of each channel divisor.
- SEL_W, $clog2(NUM_CH), width of the select input.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- div_i  input  NUM_CH*DIV_W  packed channel divisors; channel k at bits [k*DIV_W +: DIV_W].
- sel  input  SEL_W  requested channel.
- s_clk  output  1  registered divided clock of the active channel.
- s_stb  output  1  one-cycle pulse coincident with each s_clk rising edge.
- cur_sel  output  SEL_W  channel currently driving s_clk.
- busy  output  1  a switch is pending.
- sel_err  output  1  one-cycle pulse when sel >= NUM_CH is presented in RUN or OFF.

Behaviour:
- Reset (rst=1 at a clk edge):
  - s_clk=0, s_stb=0, cur_sel=0, busy=0, sel_err=0, cnt=0.
  - d_act = channel-0 divisor. State = RUN, or OFF if the channel-0 divisor is 0.
  - Reset mid-switch discards the pending request.
- Divisor interpretation:
  - D=0 means the channel is off.
  - D=1 is treated as D=2.
  - Otherwise, the period is D clk cycles.
- d_act is latched from div_i[cur_sel] only at period start (cnt==0) or on entry to a channel. A divisor change mid-period takes effect at the next period.
- Counter: cnt runs 0..d_act-1 and wraps to 0.
- Outputs in RUN/PEND:
  - s_clk=1 while cnt < d_act - d_act/2, else 0. Example: D=3 gives high 2, low 1; D=4 gives high 2, low 2.
  - s_stb=1 exactly when cnt==0.
  - Outputs are registered with one cycle of latency from the counter value.
- States:
  - RUN: free-running. If sel != cur_sel and sel < NUM_CH, latch req=sel, set busy=1, go to PEND.
  - PEND: continue the current channel. On the cycle with cnt==d_act-1:
    - cur_sel <= req, cnt <= 0, d_act <= div_i[req], busy <= 0.
    - Next state is RUN, or OFF if the new divisor is 0.
    - The first s_stb of the new channel follows on the next cycle. No partial period is ever emitted.
  - Changes to sel while in PEND are ignored. Compare again in RUN after the switch completes.
  - OFF: s_clk=0, s_stb=0, cnt held at 0.
    - A legal sel != cur_sel switches immediately (1 cycle), with no wait.
    - If div_i[cur_sel] becomes nonzero, go to RUN with cnt=0.
- Illegal select: sel >= NUM_CH in RUN or OFF is ignored. sel_err pulses each cycle it is present and state is unchanged.
- Switch latency (bound): sel to cur_sel update is at most d_act+1 cycles in RUN, and 1 cycle in OFF.
- Simultaneous sel change and divisor change: the switch uses the divisor sampled at the switch cycle.
- Selecting the same channel never asserts busy.

Decomposition:
- Package clk_sel_pkg holds:
  - the state enum {ST_RUN, ST_PEND, ST_OFF};
  - the constant DIV_MIN=2;
  - the function eff_div(D), which maps 1 to 2 and passes other values through.
- One natural sub-module: clk_div_core. It holds cnt, d_act, and the s_clk/s_stb generation, and takes a load pulse and a new divisor.
- The select FSM lives in the top level.

Test Plan:
- Reset, div_i={ch0=4}, sel=0 → s_clk pattern 1,1,0,0 repeating; s_stb every 4 cycles; busy=0.
- Channel 0 D=6; sel 0→1 (D=3) at cnt=1:
  - busy=1 for the remaining 5 cycles.
  - cur_sel=1 after ch0 cnt==5.
  - Pattern becomes 1,1,0 with no short high pulse.
- Channel 1 D=0 selected → OFF, s_clk=0; sel→2 (D=5) → cur_sel=2 next cycle; first s_stb one cycle later; high 3, low 2.
- sel=7 with NUM_CH=4 → sel_err pulses, cur_sel unchanged; D=1 → behaves as period 2.
- rst asserted during PEND → all outputs reset next edge, cur_sel=0, busy=0, pending request lost; divisor 4→8 written mid-period → new period starts only at cnt wrap.

Source files
------------

// File: rtl/clk_sel_pkg.sv
// Shared types, constants and helpers for the clock-select divider.
// Contents: FSM state enum, minimum usable divisor, divisor normalisation.
package clk_sel_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PEND,
        ST_OFF
    } state_e;

    localparam int unsigned DIV_MIN = 2;

    // A divisor of 1 cannot produce a high and a low phase, so it runs as 2.
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d == 32'd1) ? 32'(DIV_MIN) : d;
    endfunction

endpackage

// File: rtl/clk_sel_divider_if.sv
// Bus between the clock-select divider and its user.
// master: drives div_i (packed channel divisors) and sel (requested channel);
//         observes s_clk, s_stb, cur_sel, busy, sel_err.
// slave:  the divider itself.
interface clk_sel_divider_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
);
    logic [NUM_CH*DIV_W-1:0] div_i;
    logic [SEL_W-1:0]        sel;
    logic                    s_clk;
    logic                    s_stb;
    logic [SEL_W-1:0]        cur_sel;
    logic                    busy;
    logic                    sel_err;

    modport master (
        output div_i, sel,
        input  s_clk, s_stb, cur_sel, busy, sel_err
    );

    modport slave (
        input  div_i, sel,
        output s_clk, s_stb, cur_sel, busy, sel_err
    );
endinterface

// File: rtl/clk_div_core.sv
// Period counter and registered divided-clock / strobe generator.
// Ports: clk, rst (sync, active high); run counts, load restarts a period
// with ld_div; ld_div is also relatched at every natural wrap and at reset.
// last_c flags the final cycle of the current period; s_clk/s_stb registered.
module clk_div_core
    import clk_sel_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] ld_div,
    output logic             last_c,
    output logic             s_clk,
    output logic             s_stb
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d_act;
    logic [DIV_W-1:0] d_new_c;
    logic [DIV_W-1:0] hi_len_c;

    assign d_new_c  = DIV_W'(eff_div(32'(ld_div)));
    // High phase takes the extra cycle for odd divisors.
    assign hi_len_c = d_act - (d_act >> 1);
    assign last_c   = (cnt == d_act - DIV_W'(1));

    // Counter, divisor latch and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            d_act <= d_new_c;
            s_clk <= 1'b0;
            s_stb <= 1'b0;
        end else begin
            s_clk <= run && (cnt < hi_len_c);
            s_stb <= run && (cnt == '0);
            if (load || (run && last_c)) begin
                cnt   <= '0;
                d_act <= d_new_c;
            end else if (run) begin
                cnt <= cnt + DIV_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/clk_sel_divider.sv
// Glitch-free selection among NUM_CH programmable divide channels.
// Ports: clk, rst (sync, active high); bus (slave): div_i, sel in;
// s_clk, s_stb, cur_sel, busy, sel_err out, all registered.
// A switch waits for the end of the running period; from OFF it is immediate.
module clk_sel_divider
    import clk_sel_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst,
    clk_sel_divider_if.slave   bus
);
    state_e           state;
    logic [SEL_W-1:0] req;
    logic [DIV_W-1:0] div_cur_c;
    logic [DIV_W-1:0] div_sel_c;
    logic [DIV_W-1:0] div_req_c;
    logic [DIV_W-1:0] div0_c;
    logic [DIV_W-1:0] ld_div_c;
    logic             sel_ok_c;
    logic             sel_new_c;
    logic             run_c;
    logic             load_c;
    logic             last_c;

    // Mux one channel divisor; indices beyond NUM_CH read as zero.
    function automatic logic [DIV_W-1:0] pick_div(
        input logic [NUM_CH*DIV_W-1:0] v,
        input logic [SEL_W-1:0]        idx
    );
        logic [DIV_W-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (32'(idx) == k) d = v[k*DIV_W +: DIV_W];
        end
        return d;
    endfunction

    assign div_cur_c = pick_div(bus.div_i, bus.cur_sel);
    assign div_sel_c = pick_div(bus.div_i, bus.sel);
    assign div_req_c = pick_div(bus.div_i, req);
    assign div0_c    = bus.div_i[DIV_W-1:0];
    assign sel_ok_c  = (32'(bus.sel) < NUM_CH);
    assign sel_new_c = sel_ok_c && (bus.sel != bus.cur_sel);
    assign run_c     = (state != ST_OFF);

    // Counter restart requests and the divisor to load with them.
    always_comb begin
        load_c   = 1'b0;
        ld_div_c = div_cur_c;
        if (rst) begin
            ld_div_c = div0_c;
        end else begin
            case (state)
                ST_PEND: begin
                    if (last_c) begin
                        load_c   = 1'b1;
                        ld_div_c = div_req_c;
                    end
                end
                ST_OFF: begin
                    if (sel_new_c) begin
                        load_c   = 1'b1;
                        ld_div_c = div_sel_c;
                    end else if (div_cur_c != '0) begin
                        load_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Select FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= (div0_c == '0) ? ST_OFF : ST_RUN;
            req         <= '0;
            bus.cur_sel <= '0;
            bus.busy    <= 1'b0;
            bus.sel_err <= 1'b0;
        end else begin
            bus.sel_err <= (state != ST_PEND) && !sel_ok_c;
            case (state)
                ST_RUN: begin
                    // A zero divisor seen at the wrap shuts the channel off.
                    if (last_c && (div_cur_c == '0)) begin
                        state <= ST_OFF;
                    end else if (sel_new_c) begin
                        req      <= bus.sel;
                        bus.busy <= 1'b1;
                        state    <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (last_c) begin
                        bus.cur_sel <= req;
                        bus.busy    <= 1'b0;
                        state       <= (div_req_c == '0) ? ST_OFF : ST_RUN;
                    end
                end
                ST_OFF: begin
                    if (sel_new_c) begin
                        bus.cur_sel <= bus.sel;
                        state       <= (div_sel_c == '0) ? ST_OFF : ST_RUN;
                    end else if (div_cur_c != '0) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    clk_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .run    (run_c),
        .load   (load_c),
        .ld_div (ld_div_c),
        .last_c (last_c),
        .s_clk  (bus.s_clk),
        .s_stb  (bus.s_stb)
    );
endmodule

// File: tb/tb_clk_sel_divider.sv
// Self-checking bench for clk_sel_divider: directed scenarios plus random
// select/divisor/reset traffic, compared every cycle against a period model.
module tb_clk_sel_divider;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned SEL_W  = 3;

    logic clk;
    logic rst;

    clk_sel_divider_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .SEL_W(SEL_W)) bus ();

    clk_sel_divider #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .SEL_W(SEL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a channel is off exactly when its period is zero.
    int m_per;
    int m_ph;
    int m_cur;
    int m_req;
    bit m_pend;
    bit e_clk;
    bit e_stb;
    bit e_err;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int dv(input int ch);
        return int'(bus.div_i[ch*DIV_W +: DIV_W]);
    endfunction

    function automatic int effd(input int d);
        return (d == 1) ? 2 : d;
    endfunction

    task automatic set_div(input int ch, input int d);
        bus.div_i[ch*DIV_W +: DIV_W] = DIV_W'(d);
    endtask

    task automatic model_step(input bit r);
        int  s;
        bit  legal;
        bit  at_end;
        s     = int'(bus.sel);
        legal = (s < int'(NUM_CH));
        if (r) begin
            m_cur  = 0;
            m_pend = 0;
            m_ph   = 0;
            m_per  = effd(dv(0));
            e_clk  = 0;
            e_stb  = 0;
            e_err  = 0;
            return;
        end
        e_err = !m_pend && !legal;
        e_clk = (m_per != 0) && (m_ph < m_per - m_per / 2);
        e_stb = (m_per != 0) && (m_ph == 0);
        if (m_per == 0) begin
            if (legal && s != m_cur) begin
                m_cur = s;
                m_per = effd(dv(s));
                m_ph  = 0;
            end else if (dv(m_cur) != 0) begin
                m_per = effd(dv(m_cur));
                m_ph  = 0;
            end
        end else begin
            at_end = (m_ph == m_per - 1);
            if (m_pend) begin
                if (at_end) begin
                    m_cur  = m_req;
                    m_pend = 0;
                    m_per  = effd(dv(m_req));
                    m_ph   = 0;
                end else begin
                    m_ph++;
                end
            end else begin
                if (at_end) begin
                    m_per = effd(dv(m_cur));
                    m_ph  = 0;
                end else begin
                    m_ph++;
                end
                if (legal && s != m_cur && m_per != 0) begin
                    m_pend = 1;
                    m_req  = s;
                end
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs checked at the next one.
    task automatic cycle(input bit r);
        rst = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        check("s_clk",   int'(bus.s_clk),   int'(e_clk));
        check("s_stb",   int'(bus.s_stb),   int'(e_stb));
        check("cur_sel", int'(bus.cur_sel), m_cur);
        check("busy",    int'(bus.busy),    int'(m_pend));
        check("sel_err", int'(bus.sel_err), int'(e_err));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        bus.sel   = '0;
        bus.div_i = '0;
        m_per = 0; m_ph = 0; m_cur = 0; m_req = 0; m_pend = 0;
        e_clk = 0; e_stb = 0; e_err = 0;

        // Basic divide-by-4 with fixed expected waveform.
        set_div(0, 4); set_div(1, 3); set_div(2, 5); set_div(3, 7);
        cycle(1'b1); cycle(1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0);
            check("pat4_clk", int'(bus.s_clk), ((i % 4) < 2) ? 1 : 0);
            check("pat4_stb", int'(bus.s_stb), ((i % 4) == 0) ? 1 : 0);
        end

        // Switch 6 -> 3 requested mid-period.
        set_div(0, 6); set_div(1, 3);
        bus.sel = '0;
        cycle(1'b1);
        for (int i = 0; i < 20 && m_ph != 1; i++) cycle(1'b0);
        bus.sel = SEL_W'(1);
        run(14);

        // Switch into an off channel, then out of it immediately.
        set_div(0, 4); set_div(1, 0); set_div(2, 5);
        bus.sel = '0;
        cycle(1'b1);
        run(3);
        bus.sel = SEL_W'(1);
        run(8);
        check("off_clk", int'(bus.s_clk), 0);
        bus.sel = SEL_W'(2);
        cycle(1'b0);
        check("off_switch", int'(bus.cur_sel), 2);
        run(12);

        // Illegal select, then divisor 1 acting as 2.
        bus.sel = SEL_W'(7);
        run(4);
        check("sel_err_hold", int'(bus.sel_err), 1);
        bus.sel = '0;
        set_div(0, 1);
        cycle(1'b1);
        run(6);

        // Reset while a switch is pending.
        set_div(0, 8); set_div(1, 3);
        bus.sel = '0;
        cycle(1'b1);
        run(2);
        bus.sel = SEL_W'(1);
        run(3);
        check("pend_busy", int'(bus.busy), 1);
        bus.sel = '0;
        cycle(1'b1);
        check("rst_busy", int'(bus.busy), 0);
        run(6);

        // Divisor 4 -> 8 written mid-period.
        set_div(0, 4);
        cycle(1'b1);
        run(2);
        set_div(0, 8);
        run(18);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) bus.sel = SEL_W'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0)
                set_div(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
            cycle(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
